mem_access_stage: RTL

- Memory stage that directly consumes the execute-stage ALU result: the ALU result is the data-memory address for loads and stores, and the writeback value for all other ops.
- Sits between the EX/MEM boundary and writeback.
- Drives a request/acknowledge data-memory port with variable latency and backpressures upstream with a valid/ready handshake.
- Detects misaligned accesses and memory timeouts; propagates halt and error.

---
 rtl/mem_access_stage_pkg.sv | 21 ++
 rtl/mem_timeout_ctr.sv | 37 +++
 rtl/mem_access_stage.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types and defaults for the memory access stage.
package mem_access_stage_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 15;
    localparam int CNT_W_DEF   = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WAIT   = 2'b01,
        S_HALTED = 2'b10,
        S_ERR    = 2'b11
    } state_e;

    // Halfword accesses must sit on an even address.
    function automatic logic misaligned(input logic addr_lsb,
                                        input logic is_mem);
        return is_mem && addr_lsb;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter for an outstanding memory request; flags the cycle
// on which the count reaches TIMEOUT.
module mem_timeout_ctr
    import mem_access_stage_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
        expired = en && !clr && (cnt_d == CNT_W'(TIMEOUT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues loads/stores on a req/ack port, passes other
// ALU results through, and traps on misalignment or memory timeout.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              in_mem_rd,
    input  logic              in_mem_wr,
    input  logic              in_halt,
    input  logic              in_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    output logic              err
);

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_halt_q, out_halt_d;
    logic              err_q, err_d;

    logic accept;
    logic is_mem;
    logic ctr_clr;
    logic ctr_en;
    logic ctr_expired;

    mem_timeout_ctr #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (ctr_expired)
    );

    always_comb begin
        in_ready = !rst && (state_q == S_IDLE)
                   && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        is_mem   = in_mem_rd || in_mem_wr;

        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_halt_d  = out_halt_q && !out_ready;
        err_d       = err_q;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_err
                        || misaligned(in_alu_out[0], is_mem)
                        || (in_mem_rd && in_mem_wr)) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else if (is_mem) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = in_mem_wr;
                        mem_addr_d  = in_alu_out;
                        mem_wdata_d = in_wdata;
                        ctr_clr     = 1'b1;
                        state_d     = S_WAIT;
                    end else begin
                        out_valid_d = 1'b1;
                        out_halt_d  = in_halt;
                        out_data_d  = in_alu_out;
                        if (in_halt) begin
                            state_d = S_HALTED;
                        end
                    end
                end
            end
            S_WAIT: begin
                ctr_en = !mem_ack;
                // An ack on the expiry cycle still completes normally.
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    out_halt_d  = 1'b0;
                    out_data_d  = mem_we_q ? mem_addr_q : mem_rdata;
                    state_d     = S_IDLE;
                end else if (ctr_expired) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_ERR;
                end
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_halt_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_halt_q  <= out_halt_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_halt  = out_halt_q;
    assign err       = err_q;

endmodule
